// File: rtl/sram_access_arbiter.sv
// Sequencer for the external 1M x 16 asynchronous waveform SRAM.
// Arbitrates capture writes against readout reads and drives fully
// registered strobes with fixed setup / pulse / hold / turnaround timing.
module sram_access_arbiter #(
    parameter int WR_PULSE      = 2,
    parameter int RD_WAIT       = 2,
    parameter int MAX_CONSEC_WR = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        WR_REQ,
    input  logic [19:0] WR_ADDR,
    input  logic [15:0] WR_DATA,
    output logic        WR_ACK,
    input  logic        RD_REQ,
    input  logic [19:0] RD_ADDR,
    output logic [15:0] RD_DATA,
    output logic        RD_VALID,
    output logic        BUSY,
    output logic [19:0] ADX,
    inout  wire  [15:0] DX,
    output logic        CEX,
    output logic        CEY,
    output logic        CE1,
    output logic        CE2,
    output logic        BHE,
    output logic        BLE
);

    typedef enum logic [2:0] {
        S_IDLE, S_W_SETUP, S_W_PULSE, S_W_HOLD, S_R_ACCESS, S_R_TURN
    } state_t;

    localparam logic [3:0] LP_WR_LAST = 4'(WR_PULSE - 1);
    localparam logic [3:0] LP_RD_LAST = 4'(RD_WAIT - 1);
    localparam logic [7:0] LP_MAX_WR  = 8'(MAX_CONSEC_WR);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [7:0]  r_wr_streak;
    logic        w_grant_wr;
    logic        w_grant_rd;

    logic        r_sel_n;
    logic        r_oe_n;
    logic        r_we_n;
    logic        r_dx_oe;
    logic        r_wr_ack;
    logic        r_rd_valid;
    logic [19:0] r_adx;
    logic [15:0] r_wdata;
    logic [15:0] r_rdata;

    logic        w_sel_n_nxt;
    logic        w_oe_n_nxt;
    logic        w_we_n_nxt;
    logic        w_dx_oe_nxt;
    logic        w_wr_ack_nxt;
    logic        w_rd_valid_nxt;

    // Saturating increment for the consecutive-write counter.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    // IDLE arbitration: writes win unless a pending read has waited out its streak.
    always_comb begin
        w_grant_wr = (r_state == S_IDLE) && WR_REQ &&
                     (!RD_REQ || (r_wr_streak < LP_MAX_WR));
        w_grant_rd = (r_state == S_IDLE) && !w_grant_wr && RD_REQ;
    end

    // State register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_state_nxt;
    end

    // Next-state logic; pulse and wait lengths come from r_cnt.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (w_grant_wr)      w_state_nxt = S_W_SETUP;
                        else if (w_grant_rd) w_state_nxt = S_R_ACCESS;
            S_W_SETUP:  w_state_nxt = S_W_PULSE;
            S_W_PULSE:  if (r_cnt == 4'd0)   w_state_nxt = S_W_HOLD;
            S_W_HOLD:   w_state_nxt = S_IDLE;
            S_R_ACCESS: if (r_cnt == 4'd0)   w_state_nxt = S_R_TURN;
            S_R_TURN:   w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Output decode from the next state so every pin comes straight from a flop.
    always_comb begin
        w_sel_n_nxt    = !((w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_PULSE) ||
                           (w_state_nxt == S_W_HOLD)  || (w_state_nxt == S_R_ACCESS));
        w_oe_n_nxt     = (w_state_nxt != S_R_ACCESS);
        w_we_n_nxt     = (w_state_nxt != S_W_PULSE);
        w_dx_oe_nxt    = (w_state_nxt == S_W_SETUP) || (w_state_nxt == S_W_PULSE) ||
                         (w_state_nxt == S_W_HOLD);
        w_wr_ack_nxt   = (w_state_nxt == S_W_HOLD);
        w_rd_valid_nxt = (r_state == S_R_ACCESS) && (w_state_nxt == S_R_TURN);
    end

    // Dwell counter, loaded on entry to the timed states and run down to zero.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_cnt <= 4'd0;
        else if ((w_state_nxt == S_W_PULSE) && (r_state != S_W_PULSE))
            r_cnt <= LP_WR_LAST;
        else if ((w_state_nxt == S_R_ACCESS) && (r_state != S_R_ACCESS))
            r_cnt <= LP_RD_LAST;
        else if (r_cnt != 4'd0)
            r_cnt <= r_cnt - 4'd1;
    end

    // Write streak only counts grants made while a read is waiting.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            r_wr_streak <= 8'd0;
        else if (r_state == S_IDLE) begin
            if (!RD_REQ)         r_wr_streak <= 8'd0;
            else if (w_grant_wr) r_wr_streak <= sat_inc8(r_wr_streak);
            else                 r_wr_streak <= 8'd0;
        end
    end

    // Registered strobes and handshake pulses; reset floats DX and parks strobes high.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_sel_n    <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_dx_oe    <= 1'b0;
            r_wr_ack   <= 1'b0;
            r_rd_valid <= 1'b0;
        end else begin
            r_sel_n    <= w_sel_n_nxt;
            r_oe_n     <= w_oe_n_nxt;
            r_we_n     <= w_we_n_nxt;
            r_dx_oe    <= w_dx_oe_nxt;
            r_wr_ack   <= w_wr_ack_nxt;
            r_rd_valid <= w_rd_valid_nxt;
        end
    end

    // Address and data capture at the grant edge, read data at the end of R_ACCESS.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_adx   <= 20'd0;
            r_wdata <= 16'd0;
            r_rdata <= 16'd0;
        end else begin
            if (w_grant_wr) begin
                r_adx   <= WR_ADDR;
                r_wdata <= WR_DATA;
            end else if (w_grant_rd) begin
                r_adx   <= RD_ADDR;
            end
            if (w_rd_valid_nxt)
                r_rdata <= DX;
        end
    end

    assign DX       = r_dx_oe ? r_wdata : 16'hzzzz;
    assign ADX      = r_adx;
    assign CE1      = r_sel_n;
    assign BHE      = r_sel_n;
    assign BLE      = r_sel_n;
    assign CEX      = r_oe_n;
    assign CEY      = r_we_n;
    assign CE2      = 1'b1;
    assign WR_ACK   = r_wr_ack;
    assign RD_VALID = r_rd_valid;
    assign RD_DATA  = r_rdata;
    assign BUSY     = (r_state != S_IDLE);

endmodule

// File: tb/tb_sram_access_arbiter.sv
// Bench for sram_access_arbiter: SRAM model, bus probe, transaction-level
// reference model with a per-cycle compare, directed and random traffic.
module tb_sram_access_arbiter;

    localparam int WR_PULSE      = 2;
    localparam int RD_WAIT       = 2;
    localparam int MAX_CONSEC_WR = 8;
    localparam logic [15:0] PROBE = 16'h5AA5;

    logic        CLK = 1'b0;
    logic        RST;
    logic        WR_REQ, RD_REQ;
    logic [19:0] WR_ADDR, RD_ADDR;
    logic [15:0] WR_DATA;
    logic        WR_ACK, RD_VALID, BUSY;
    logic [15:0] RD_DATA;
    logic [19:0] ADX;
    logic        CEX, CEY, CE1, CE2, BHE, BLE;
    wire  [15:0] DX;

    sram_access_arbiter #(
        .WR_PULSE(WR_PULSE), .RD_WAIT(RD_WAIT), .MAX_CONSEC_WR(MAX_CONSEC_WR)
    ) dut (
        .CLK(CLK), .RST(RST),
        .WR_REQ(WR_REQ), .WR_ADDR(WR_ADDR), .WR_DATA(WR_DATA), .WR_ACK(WR_ACK),
        .RD_REQ(RD_REQ), .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA), .RD_VALID(RD_VALID),
        .BUSY(BUSY), .ADX(ADX), .DX(DX),
        .CEX(CEX), .CEY(CEY), .CE1(CE1), .CE2(CE2), .BHE(BHE), .BLE(BLE)
    );

    always #5 CLK = ~CLK;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic report_timeout(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: wait bound expired (t=%0t)", name, $time);
    endtask

    // Unwritten locations read back a fixed address-derived pattern.
    function automatic logic [15:0] init_val(input logic [19:0] a);
        return a[15:0] ^ 16'hC3C3;
    endfunction

    // ---------------- asynchronous SRAM model and bus probe ----------------
    logic [15:0] mem [int];
    logic [15:0] sram_q;

    function automatic logic [15:0] mem_rd(input logic [19:0] a);
        if (mem.exists(int'(a))) return mem[int'(a)];
        return init_val(a);
    endfunction

    always @(posedge CEY) if (!RST && !CE1) mem[int'(ADX)] = DX;
    always @(ADX or CEX or CEY or CE1) sram_q = mem_rd(ADX);

    // SRAM drives during reads; the probe pattern is driven whenever the chip
    // is deselected, so reading it back proves the arbiter has released DX.
    assign DX = (!CE1 && !CEX && CEY) ? sram_q : ((CE1 && CEX) ? PROBE : 16'hzzzz);

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        ce1, cex, cey, ack, vld, busy, commit;
        logic [15:0] dx;
        logic [19:0] adx;
        logic [15:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [15:0] sb [int];
    int          m_streak = 0;
    logic [19:0] m_adx    = 20'd0;
    logic [15:0] m_rdata  = 16'd0;
    logic [19:0] prev_adx = 20'd0;
    logic        prev_cey = 1'b1;

    function automatic logic [15:0] sb_rd(input logic [19:0] a);
        if (sb.exists(int'(a))) return sb[int'(a)];
        return init_val(a);
    endfunction

    task automatic push_write(input logic [19:0] a, input logic [15:0] d);
        exp_t e;
        for (int i = 0; i < WR_PULSE + 2; i++) begin
            e.ce1 = 1'b0; e.cex = 1'b1; e.vld = 1'b0; e.busy = 1'b1;
            e.cey = !(i >= 1 && i <= WR_PULSE);
            e.ack = (i == WR_PULSE + 1);
            e.commit = e.ack;
            e.dx = d; e.adx = a; e.rdata = m_rdata;
            q.push_back(e);
        end
        m_adx = a;
    endtask

    task automatic push_read(input logic [19:0] a);
        exp_t        e;
        logic [15:0] v;
        v = sb_rd(a);
        for (int i = 0; i < RD_WAIT; i++) begin
            e.ce1 = 1'b0; e.cex = 1'b0; e.cey = 1'b1; e.ack = 1'b0; e.vld = 1'b0;
            e.busy = 1'b1; e.commit = 1'b0; e.dx = v; e.adx = a; e.rdata = m_rdata;
            q.push_back(e);
        end
        e.ce1 = 1'b1; e.cex = 1'b1; e.cey = 1'b1; e.ack = 1'b0; e.vld = 1'b1;
        e.busy = 1'b1; e.commit = 1'b0; e.dx = PROBE; e.adx = a; e.rdata = v;
        q.push_back(e);
        m_adx = a; m_rdata = v;
    endtask

    task automatic check_vec(input exp_t e);
        check("strobes", 32'({CE1, CEX, CEY, BHE, BLE, CE2, WR_ACK, RD_VALID, BUSY}),
              32'({e.ce1, e.cex, e.cey, e.ce1, e.ce1, 1'b1, e.ack, e.vld, e.busy}));
        check("adx", 32'(ADX), 32'(e.adx));
        check("rd_data", 32'(RD_DATA), 32'(e.rdata));
        check("dx_bus", 32'(DX), 32'(e.dx));
    endtask

    // Per-cycle compare against the model, sampled on the falling edge.
    always @(negedge CLK) begin : cmp
        exp_t e;
        if (RST) begin
            q.delete();
            m_streak = 0; m_adx = 20'd0; m_rdata = 16'd0;
            e = '{ce1:1'b1, cex:1'b1, cey:1'b1, ack:1'b0, vld:1'b0, busy:1'b0,
                  commit:1'b0, dx:PROBE, adx:20'd0, rdata:16'd0};
            check_vec(e);
            prev_cey = 1'b1; prev_adx = 20'd0;
        end else begin
            if (q.size() == 0) begin
                e = '{ce1:1'b1, cex:1'b1, cey:1'b1, ack:1'b0, vld:1'b0, busy:1'b0,
                      commit:1'b0, dx:PROBE, adx:m_adx, rdata:m_rdata};
                check_vec(e);
                if (WR_REQ && (!RD_REQ || m_streak < MAX_CONSEC_WR)) begin
                    push_write(WR_ADDR, WR_DATA);
                    m_streak = RD_REQ ? ((m_streak >= 255) ? 255 : m_streak + 1) : 0;
                end else if (RD_REQ) begin
                    push_read(RD_ADDR);
                    m_streak = 0;
                end else begin
                    m_streak = 0;
                end
            end else begin
                e = q.pop_front();
                check_vec(e);
                if (e.commit) sb[int'(e.adx)] = e.dx;
            end
            check("oe_we_overlap", 32'(CEX | CEY), 32'd1);
            if (prev_cey && !CEY) check("adx_stable_at_we_fall", 32'(ADX), 32'(prev_adx));
            prev_cey = CEY; prev_adx = ADX;
        end
    end

    // ---------------- event monitor ----------------
    int cyc = 0, wr_ack_cnt = 0, rd_vld_cnt = 0, cey_low = 0, cex_low = 0;
    int t_wrack = 0, t_rdv = 0, t_busy_rise = 0;
    logic prev_busy = 1'b0;

    always @(negedge CLK) begin
        cyc++;
        if (WR_ACK)   begin wr_ack_cnt++; t_wrack = cyc; end
        if (RD_VALID) begin rd_vld_cnt++; t_rdv = cyc; end
        if (!CEY) cey_low++;
        if (!CEX) cex_low++;
        if (BUSY && !prev_busy) t_busy_rise = cyc;
        prev_busy = BUSY;
    end

    // ---------------- requester side ----------------
    int wr_ack_used = 0, rd_vld_used = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [19:0] rand_addr();
        return 20'hFFFF8 + 20'($urandom_range(0, 15));
    endfunction

    task automatic do_write(input logic [19:0] a, input logic [15:0] d);
        int n = 0;
        WR_ADDR = a; WR_DATA = d; WR_REQ = 1'b1;
        while (wr_ack_cnt == wr_ack_used && n < 50) begin tick(); n++; end
        if (n >= 50) report_timeout("write_ack_wait");
        wr_ack_used = wr_ack_cnt;
        WR_REQ = 1'b0;
    endtask

    task automatic do_read(input logic [19:0] a);
        int n = 0;
        RD_ADDR = a; RD_REQ = 1'b1;
        while (rd_vld_cnt == rd_vld_used && n < 50) begin tick(); n++; end
        if (n >= 50) report_timeout("read_valid_wait");
        rd_vld_used = rd_vld_cnt;
        RD_REQ = 1'b0;
    endtask

    task automatic serve_drops(output int done);
        done = 0;
        if (WR_REQ && wr_ack_cnt != wr_ack_used) begin
            wr_ack_used = wr_ack_cnt; WR_REQ = 1'b0; done++;
        end
        if (RD_REQ && rd_vld_cnt != rd_vld_used) begin
            rd_vld_used = rd_vld_cnt; RD_REQ = 1'b0; done++;
        end
    endtask

    initial begin : main
        int c0, c1, n, done, k, wr_at_rd, wr_between, n_acc, wr_age, rd_age, acks0;
        bit rd_done;
        RST = 1'b1; WR_REQ = 1'b0; RD_REQ = 1'b0;
        WR_ADDR = 20'd0; WR_DATA = 16'd0; RD_ADDR = 20'd0;
        repeat (3) tick();
        check("reset_adx", 32'(ADX), 32'd0);
        check("reset_busy", 32'(BUSY), 32'd0);
        RST = 1'b0;
        repeat (2) tick();

        // Single write: WE_n low for WR_PULSE clocks, ACK three clocks after grant.
        c0 = cey_low;
        do_write(20'h00010, 16'h03A5);
        tick();
        check("wr_we_low_clks", 32'(cey_low - c0), 32'd2);
        check("wr_grant_to_ack", 32'(t_wrack - t_busy_rise), 32'd3);

        // Single read of the same location.
        c0 = cex_low; c1 = rd_vld_cnt;
        do_read(20'h00010);
        tick();
        check("rd_value", 32'(RD_DATA), 32'h03A5);
        check("rd_oe_low_clks", 32'(cex_low - c0), 32'd2);
        check("rd_valid_pulses", 32'(rd_vld_cnt - c1), 32'd1);
        repeat (2) tick();

        // Simultaneous requests: write first, read granted in the next IDLE cycle.
        WR_ADDR = 20'h00020; WR_DATA = 16'h1234; WR_REQ = 1'b1;
        RD_ADDR = 20'h00010; RD_REQ = 1'b1;
        n = 0;
        while ((WR_REQ || RD_REQ) && n < 40) begin tick(); serve_drops(done); n++; end
        if (n >= 40) report_timeout("simul_wait");
        check("simul_ack_to_valid", 32'(t_rdv - t_wrack), 32'd4);
        check("simul_rd_value", 32'(RD_DATA), 32'h03A5);
        do_write(20'h00021, 16'h4321);
        repeat (2) tick();

        // Continuous writes with a read raised alongside: 8 writes, then the read.
        WR_ADDR = 20'h00100; WR_DATA = 16'h0100; WR_REQ = 1'b1;
        k = 0; rd_done = 0; wr_between = -1; wr_at_rd = 0; n = 0;
        while (n < 400) begin
            tick(); n++;
            if (wr_ack_cnt != wr_ack_used) begin
                wr_ack_used = wr_ack_cnt; k++;
                WR_ADDR = 20'h00100 + 20'(k); WR_DATA = 16'($urandom);
                if (k == 3) begin RD_ADDR = 20'h00010; RD_REQ = 1'b1; wr_at_rd = wr_ack_cnt; end
                if (rd_done && wr_ack_cnt - wr_at_rd >= wr_between + 2) begin
                    WR_REQ = 1'b0; break;
                end
            end
            if (RD_REQ && rd_vld_cnt != rd_vld_used) begin
                rd_vld_used = rd_vld_cnt; RD_REQ = 1'b0; rd_done = 1;
                wr_between = wr_ack_cnt - wr_at_rd;
            end
        end
        if (n >= 400) begin report_timeout("streak_wait"); WR_REQ = 1'b0; RD_REQ = 1'b0; end
        check("streak_writes_before_read", 32'(wr_between), 32'd8);
        check("streak_rd_value", 32'(RD_DATA), 32'h03A5);
        repeat (3) tick();

        // Reset during the write pulse: strobes high and bus released at once.
        WR_ADDR = 20'h00030; WR_DATA = 16'hBEEF; WR_REQ = 1'b1;
        n = 0;
        while (CEY !== 1'b0 && n < 20) begin tick(); n++; end
        if (n >= 20) report_timeout("rst_pulse_wait");
        #1 RST = 1'b1;
        #1;
        check("rst_we_high", 32'(CEY), 32'd1);
        check("rst_ce1_high", 32'(CE1), 32'd1);
        check("rst_dx_float", 32'(DX), 32'(PROBE));
        acks0 = wr_ack_cnt;
        WR_REQ = 1'b0;
        repeat (2) tick();
        RST = 1'b0;
        repeat (3) tick();
        check("rst_no_ack", 32'(wr_ack_cnt), 32'(acks0));
        do_write(20'h00030, 16'h1357);
        do_read(20'h00030);
        tick();
        check("post_rst_rd_value", 32'(RD_DATA), 32'h1357);
        repeat (2) tick();

        // Random traffic over a small wrapping address window.
        n_acc = 0; wr_age = 0; rd_age = 0; n = 0;
        while (n_acc < 10000 && n < 80000) begin
            tick(); n++;
            serve_drops(done);
            n_acc += done;
            if (!WR_REQ && $urandom_range(0, 7) != 0) begin
                WR_ADDR = rand_addr(); WR_DATA = 16'($urandom); WR_REQ = 1'b1; wr_age = 0;
            end else if (WR_REQ) wr_age++;
            if (!RD_REQ && $urandom_range(0, 7) != 0) begin
                RD_ADDR = rand_addr(); RD_REQ = 1'b1; rd_age = 0;
            end else if (RD_REQ) rd_age++;
            if (wr_age > 200 || rd_age > 200) begin report_timeout("random_req_age"); break; end
        end
        check("random_access_count", 32'(n_acc >= 10000), 32'd1);
        n = 0;
        while ((WR_REQ || RD_REQ) && n < 100) begin tick(); serve_drops(done); n++; end
        if (n >= 100) report_timeout("drain_wait");
        WR_REQ = 1'b0; RD_REQ = 1'b0;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
